// File: rtl/host_guess_checker_pkg.sv
// Shared types and constants for the host-side hangman guess checker.
package hangman_pkg;

    localparam int WORD_LEN     = 5;
    localparam int MAX_MISTAKES = 6;

    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_Z = 8'h5A;

    typedef enum logic [2:0] {
        NO_GAME,
        IDLE,
        CHECK,
        UPDATE,
        DONE
    } state_t;

    // Maps 'A'..'Z' onto 0..25 for the guessed-letter set.
    function automatic logic [4:0] letter_idx(input logic [7:0] ch);
        return 5'(ch - ASCII_A);
    endfunction

endpackage

// File: rtl/host_guess_checker_if.sv
// Guess handshake from the receiver (UART/keypad path) into the checker.
interface host_guess_checker_if;

    logic       guessValid;
    logic [7:0] guess;
    logic       guessReady;

    modport master (output guessValid, output guess, input guessReady);
    modport slave  (input guessValid, input guess, output guessReady);

endinterface

// File: rtl/host_guess_checker_history.sv
// Set of letters already guessed in the current game, indexed by letter_idx.
module guess_history (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       set_en,
    input  logic [4:0] set_idx,
    input  logic [4:0] lookup_idx,
    output logic       hit
);

    logic [25:0] seen;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            seen <= '0;
        end else if (set_en && (set_idx < 5'd26)) begin
            seen[set_idx] <= 1'b1;
        end
    end

    assign hit = (lookup_idx < 5'd26) ? seen[lookup_idx] : 1'b0;

endmodule

// File: rtl/host_guess_checker.sv
// Hangman game engine: latches the word, scores guesses one character per cycle.
//   state   | meaning
//   NO_GAME | after reset, waiting for newGame
//   IDLE    | ready for a guess
//   CHECK   | comparing the letter against char idx
//   UPDATE  | committing the pending mask to the outputs
//   DONE    | game won or lost, outputs frozen
module host_guess_checker #(
    parameter int WORD_LEN     = hangman_pkg::WORD_LEN,
    parameter int MAX_MISTAKES = hangman_pkg::MAX_MISTAKES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    newGame,
    input  logic [8*WORD_LEN-1:0]   word,
    host_guess_checker_if.slave     gif,
    output logic [7:0]              letter,
    output logic [WORD_LEN-1:0]     indexCorrect,
    output logic [2:0]              correct,
    output logic                    mistake,
    output logic [2:0]              incorrect,
    output logic                    gameEnd_host,
    output logic                    win
);
    import hangman_pkg::*;

    state_t                state, state_d;
    logic [8*WORD_LEN-1:0] word_q, word_d;
    logic [7:0]            letter_d, cur_char;
    logic [WORD_LEN-1:0]   ic_d, pending, pend_d;
    logic [2:0]            correct_d, inc_d, idx, idx_d;
    logic                  mistake_d, end_d, win_d;
    logic                  hist_clr, hist_set, hist_hit;

    function automatic logic [2:0] popcount(input logic [WORD_LEN-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < WORD_LEN; i++) cnt = cnt + 3'(v[i]);
        return cnt;
    endfunction

    guess_history u_history (
        .clk        (clk),
        .rst        (rst),
        .clr        (hist_clr),
        .set_en     (hist_set),
        .set_idx    (letter_idx(letter)),
        .lookup_idx (letter_idx(letter)),
        .hit        (hist_hit)
    );

    assign gif.guessReady = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= NO_GAME;
            word_q       <= '0;
            letter       <= '0;
            indexCorrect <= '0;
            correct      <= '0;
            mistake      <= 1'b0;
            incorrect    <= '0;
            gameEnd_host <= 1'b0;
            win          <= 1'b0;
            idx          <= '0;
            pending      <= '0;
        end else begin
            state        <= state_d;
            word_q       <= word_d;
            letter       <= letter_d;
            indexCorrect <= ic_d;
            correct      <= correct_d;
            mistake      <= mistake_d;
            incorrect    <= inc_d;
            gameEnd_host <= end_d;
            win          <= win_d;
            idx          <= idx_d;
            pending      <= pend_d;
        end
    end

    always_comb begin
        state_d   = state;
        word_d    = word_q;
        letter_d  = letter;
        ic_d      = indexCorrect;
        correct_d = correct;
        mistake_d = 1'b0;
        inc_d     = incorrect;
        end_d     = gameEnd_host;
        win_d     = win;
        idx_d     = idx;
        pend_d    = pending;
        hist_clr  = 1'b0;
        hist_set  = 1'b0;
        cur_char  = 8'(word_q >> (8 * (WORD_LEN - 1 - int'(idx))));

        // newGame overrides everything, including a guess arriving the same cycle.
        if (newGame) begin
            state_d   = IDLE;
            word_d    = word;
            letter_d  = '0;
            ic_d      = '0;
            correct_d = '0;
            inc_d     = '0;
            end_d     = 1'b0;
            win_d     = 1'b0;
            idx_d     = '0;
            pend_d    = '0;
            hist_clr  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gif.guessValid && (gif.guess >= ASCII_A) && (gif.guess <= ASCII_Z)) begin
                        letter_d = gif.guess;
                        idx_d    = '0;
                        pend_d   = '0;
                        state_d  = CHECK;
                    end
                end
                CHECK: begin
                    if (cur_char == letter) pend_d[WORD_LEN - 1 - int'(idx)] = 1'b1;
                    if (idx == 3'(WORD_LEN - 1)) state_d = UPDATE;
                    else                          idx_d   = idx + 3'd1;
                end
                UPDATE: begin
                    if (!hist_hit) begin
                        hist_set = 1'b1;
                        if (pending == '0) begin
                            mistake_d = 1'b1;
                            correct_d = '0;
                            if (incorrect < 3'(MAX_MISTAKES)) inc_d = incorrect + 3'd1;
                        end else begin
                            correct_d = popcount(pending & ~indexCorrect);
                            ic_d      = indexCorrect | pending;
                        end
                        if (&ic_d) begin
                            win_d = 1'b1;
                            end_d = 1'b1;
                        end else if (inc_d == 3'(MAX_MISTAKES)) begin
                            end_d = 1'b1;
                        end
                    end
                    state_d = end_d ? DONE : IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_host_guess_checker.sv
// Directed bench for host_guess_checker using the word "MOORE".
module tb_host_guess_checker;
    import hangman_pkg::*;

    localparam logic [39:0] MOORE = 40'h4D4F4F5245;

    logic        tb_clk = 1'b0;
    logic        rst;
    logic        newGame;
    logic [39:0] word;
    logic [7:0]  letter;
    logic [4:0]  indexCorrect;
    logic [2:0]  correct;
    logic        mistake;
    logic [2:0]  incorrect;
    logic        gameEnd_host;
    logic        win;

    int n_tests   = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;

    logic [7:0] miss [4];

    host_guess_checker_if gif ();

    host_guess_checker dut (
        .clk          (tb_clk),
        .rst          (rst),
        .newGame      (newGame),
        .word         (word),
        .gif          (gif),
        .letter       (letter),
        .indexCorrect (indexCorrect),
        .correct      (correct),
        .mistake      (mistake),
        .incorrect    (incorrect),
        .gameEnd_host (gameEnd_host),
        .win          (win)
    );

    always #5 tb_clk = ~tb_clk;

    always @(negedge tb_clk) if (mistake === 1'b1) pulse_cnt++;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic send(input logic [7:0] ch);
        @(negedge tb_clk);
        gif.guessValid = 1'b1;
        gif.guess      = ch;
        @(negedge tb_clk);
        gif.guessValid = 1'b0;
    endtask

    task automatic guess_commit(input logic [7:0] ch);
        send(ch);
        tick(6);
    endtask

    task automatic start_game();
        @(negedge tb_clk);
        newGame = 1'b1;
        word    = MOORE;
        @(negedge tb_clk);
        newGame = 1'b0;
    endtask

    initial begin
        miss[0] = 8'h41; miss[1] = 8'h42; miss[2] = 8'h43; miss[3] = 8'h44;
        rst = 1'b1; newGame = 1'b0; word = '0;
        gif.guessValid = 1'b0; gif.guess = '0;
        tick(3);
        rst = 1'b0;

        // reset state
        chk("rst_ready",   gif.guessReady, 1'b0);
        chk("rst_letter",  letter, 8'h00);
        chk("rst_ic",      indexCorrect, 5'b00000);
        chk("rst_inc",     incorrect, 3'd0);
        chk("rst_end",     {gameEnd_host, win, mistake, correct}, 6'd0);
        send(8'h4D);
        chk("nogame_ignore", letter, 8'h00);

        // single wrong guess 'P'
        start_game();
        chk("ng_ready", gif.guessReady, 1'b1);
        send(8'h50);
        chk("p_ready_drop", gif.guessReady, 1'b0);
        tick(5);
        chk("p_mistake_early", mistake, 1'b0);
        tick(1);
        chk("p_mistake",   mistake, 1'b1);
        chk("p_incorrect", incorrect, 3'd1);
        chk("p_ic",        indexCorrect, 5'b00000);
        chk("p_correct",   correct, 3'd0);
        chk("p_letter",    letter, 8'h50);
        chk("p_ready",     gif.guessReady, 1'b1);
        tick(1);
        chk("p_mistake_end", mistake, 1'b0);

        // M, O, repeat O
        start_game();
        guess_commit(8'h4D);
        chk("m_ic", indexCorrect, 5'b10000);
        chk("m_correct", correct, 3'd1);
        chk("m_mistake", mistake, 1'b0);
        guess_commit(8'h4F);
        chk("o_ic", indexCorrect, 5'b11100);
        chk("o_correct", correct, 3'd2);
        guess_commit(8'h4F);
        chk("oo_ic", indexCorrect, 5'b11100);
        chk("oo_correct", correct, 3'd2);
        chk("oo_mistake", {mistake, incorrect}, 4'd0);

        // win: M O R E
        start_game();
        guess_commit(8'h4D);
        guess_commit(8'h4F);
        guess_commit(8'h52);
        chk("r_ic", indexCorrect, 5'b11110);
        chk("r_end", gameEnd_host, 1'b0);
        guess_commit(8'h45);
        chk("win_ic", indexCorrect, 5'b11111);
        chk("win_correct", correct, 3'd1);
        chk("win_flags", {win, gameEnd_host}, 2'b11);
        chk("win_ready", gif.guessReady, 1'b0);
        @(negedge tb_clk);
        gif.guessValid = 1'b1;
        gif.guess      = 8'h58;
        tick(3);
        gif.guessValid = 1'b0;
        tick(6);
        chk("done_letter", letter, 8'h45);
        chk("done_hold", {win, gameEnd_host, indexCorrect}, 7'b1111111);

        // loss: A B C D, repeat A, F G
        start_game();
        pulse_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            guess_commit(miss[i]);
            chk("loss_incorrect", incorrect, 40'(i + 1));
        end
        guess_commit(8'h41);
        chk("rep_a_incorrect", incorrect, 3'd4);
        chk("rep_a_mistake", mistake, 1'b0);
        guess_commit(8'h46);
        chk("f_incorrect", incorrect, 3'd5);
        chk("f_end", gameEnd_host, 1'b0);
        guess_commit(8'h47);
        chk("g_incorrect", incorrect, 3'd6);
        chk("loss_flags", {gameEnd_host, win}, 2'b10);
        chk("loss_ready", gif.guessReady, 1'b0);
        tick(1);
        chk("loss_pulses", 40'(pulse_cnt), 40'd6);

        // non-letter, then reset mid-check
        start_game();
        send(8'h35);
        chk("digit_ready", gif.guessReady, 1'b1);
        chk("digit_letter", letter, 8'h00);
        send(8'h4D);
        chk("abort_letter_pre", letter, 8'h4D);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("abort_letter", letter, 8'h00);
        chk("abort_ready", gif.guessReady, 1'b0);
        tick(6);
        chk("abort_outputs", {indexCorrect, correct, mistake, incorrect, gameEnd_host, win}, 14'd0);

        // newGame together with guessValid
        start_game();
        guess_commit(8'h50);
        chk("pre_ng_incorrect", incorrect, 3'd1);
        @(negedge tb_clk);
        newGame        = 1'b1;
        word           = MOORE;
        gif.guessValid = 1'b1;
        gif.guess      = 8'h4D;
        @(negedge tb_clk);
        newGame        = 1'b0;
        gif.guessValid = 1'b0;
        chk("ngv_ready", gif.guessReady, 1'b1);
        chk("ngv_cleared", {letter, incorrect}, 11'd0);
        tick(7);
        chk("ngv_dropped", {indexCorrect, letter}, 13'd0);
        chk("ngv_ready_after", gif.guessReady, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/host_guess_checker.md
# host_guess_checker

Game-logic engine on the host side of the hangman link. It latches the secret 5-letter word at the start of each game and accepts single guessed letters through a valid/ready handshake. It scores each guess serially against the word and produces the status signals consumed by the host display: `letter`, `indexCorrect`, `correct`, `mistake`, `incorrect`, `gameEnd_host`. It sits between the guess receiver (UART/keypad path) and `HostDisplay`, and is the producer for that block's inputs.

## Interface
Parameters:
- `WORD_LEN`, 5: letters per word; `word` is `8*WORD_LEN` bits.
- `MAX_MISTAKES`, 6: wrong guesses that end the game as a loss.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `newGame`  in  1  one-cycle pulse: latch `word`, clear game state.
- `word`  in  40  ASCII word; char 0 in `[39:32]`, char 4 in `[7:0]`.
- `guessValid`  in  1  `guess` is valid.
- `guess`  in  8  ASCII guessed letter.
- `guessReady`  out  1  checker can accept a guess; high only in IDLE.
- `letter`  out  8  last accepted guess.
- `indexCorrect`  out  5  cumulative revealed-position mask; bit 4 = char 0.
- `correct`  out  3  positions newly revealed by the last scored guess (0..5).
- `mistake`  out  1  one-cycle pulse per scored wrong guess.
- `incorrect`  out  3  cumulative wrong guesses, saturates at `MAX_MISTAKES`.
- `gameEnd_host`  out  1  level; high after a win or loss until `newGame`/`rst`.
- `win`  out  1  level; high with `gameEnd_host` on a win only.

## Operation
- States: NO_GAME, IDLE, CHECK, UPDATE, DONE.
- Reset: state NO_GAME. Word register, `letter`, `indexCorrect`, `correct`, `mistake`, `incorrect`, `gameEnd_host`, `win`, and guess history all reset to 0. `guessReady` = 0.
- `newGame` (any state, priority below `rst`): latch `word`, clear every output and the history, go to IDLE. A simultaneous `guessValid` is dropped.
- IDLE: `guessValid && guessReady` accepts the guess.
  - Guesses outside 0x41–0x5A are consumed and discarded, with no output change.
  - A valid letter is registered into `letter` and the state goes to CHECK with index 0 and a cleared pending mask.
- CHECK: one char per cycle; index 0..WORD_LEN-1. On a match, set the pending mask bit `4-index`. After the last index, go to UPDATE.
- UPDATE: commit the result, then go to IDLE, or to DONE if the game ended.
  - Repeat guess (letter already in the 26-bit history): no output change, no pulse.
  - Else if the pending mask is 0: `mistake`=1 for one cycle, `incorrect`+=1, `correct`=0.
  - Else: `correct` = popcount(pending & ~indexCorrect), `indexCorrect` |= pending.
  - In all non-repeat cases, set the letter's history bit.
  - Win: `indexCorrect`==5'b11111 sets `win`=1 and `gameEnd_host`=1.
  - Loss: `incorrect`==`MAX_MISTAKES` sets `gameEnd_host`=1 and `win`=0.
  - If both conditions would hold in the same commit, win takes precedence (not reachable with distinct letters).
- DONE: `guessReady`=0; outputs hold until `newGame`/`rst`.
- `rst` or `newGame` during CHECK/UPDATE aborts the guess; no partial commit.

## Timing
- The accept edge is edge 0. CHECK spans edges 1..WORD_LEN. UPDATE commits at edge WORD_LEN+1 (edge 6 by default).
- Results are visible in the cycle after the commit edge. `mistake` is high for exactly that one cycle.
- `guessReady` drops on the cycle after accept. It returns in the cycle after commit, unless the game ended.
- Maximum throughput: one guess per WORD_LEN+2 cycles.
- All outputs are registered; no combinational input-to-output path.
- `incorrect` arithmetic is 3-bit and never exceeds `MAX_MISTAKES`.
- `correct` is 3-bit; its maximum is 5.

## Structure
- `hangman_pkg` holds:
  - the state enum;
  - `WORD_LEN`, `MAX_MISTAKES`;
  - `ASCII_A`=8'h41, `ASCII_Z`=8'h5A;
  - function `letter_idx(8-bit) -> 5-bit`.
- Sub-module `guess_history`: a 26-bit guessed-letter set with clear, set, and lookup ports, reset to 0.
- The FSM, serial comparator, and popcount live in the top module.

## Test plan
All scenarios use `rst`, then `newGame` with word "MOORE" (0x4D4F4F5245).
- Guess 'P' (0x50) → 6 cycles after accept: `mistake` pulse of 1 cycle, `incorrect`=1, `indexCorrect`=00000, `correct`=0, `letter`=0x50.
- Guess 'M' → `indexCorrect`=10000, `correct`=1, no pulse. Then guess 'O' → `indexCorrect`=11100, `correct`=2. Then 'O' again → no change, no pulse.
- Guess M, O, R, E → `indexCorrect`=11111, `win`=1, `gameEnd_host`=1, `guessReady`=0. A further `guessValid` is ignored.
- Guess A, B, C, D, F, G → `incorrect` counts 1..6, six pulses, `gameEnd_host`=1, `win`=0. Repeating 'A' before the end leaves `incorrect` unchanged.
- Guess '5' (0x35) → accepted, no output change, `guessReady` high next cycle. Assert `rst` at CHECK index 2 → all outputs 0, state NO_GAME.
- Assert `newGame` together with `guessValid` in IDLE → guess dropped, state cleared, `guessReady`=1.
